// File: rtl/decode_execute_reg_if.sv
// Decode/execute boundary bundle: D-side fields in, E-side fields out,
// plus pipeline control (stall, flush) and hazard/perf status.
interface decode_execute_reg_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  valid_d_i;
    logic [DATA_WIDTH-1:0] RD1D_i;
    logic [DATA_WIDTH-1:0] RD2D_i;
    logic [DATA_WIDTH-1:0] ImmExtD_i;
    logic [DATA_WIDTH-1:0] PCD_i;
    logic [DATA_WIDTH-1:0] PC_Plus4D_i;
    logic [4:0]            Rs1D_i;
    logic [4:0]            Rs2D_i;
    logic [4:0]            RdD_i;
    logic                  RegWriteD_i;
    logic [1:0]            ResultSrcD_i;
    logic                  MemWriteD_i;
    logic                  JumpD_i;
    logic                  BranchD_i;
    logic                  ALUSrcD_i;
    logic [3:0]            ALUControlD_i;
    logic                  stall_i;
    logic                  flush_i;

    logic                  valid_e_o;
    logic [DATA_WIDTH-1:0] RD1E_o;
    logic [DATA_WIDTH-1:0] RD2E_o;
    logic [DATA_WIDTH-1:0] ImmExtE_o;
    logic [DATA_WIDTH-1:0] PCE_o;
    logic [DATA_WIDTH-1:0] PC_Plus4E_o;
    logic [4:0]            Rs1E_o;
    logic [4:0]            Rs2E_o;
    logic [4:0]            RdE_o;
    logic                  RegWriteE_o;
    logic [1:0]            ResultSrcE_o;
    logic                  MemWriteE_o;
    logic                  JumpE_o;
    logic                  BranchE_o;
    logic                  ALUSrcE_o;
    logic [3:0]            ALUControlE_o;
    logic                  lu_stall_o;
    logic [CNT_WIDTH-1:0]  bubble_cnt_o;

    modport master (
        output valid_d_i, RD1D_i, RD2D_i, ImmExtD_i, PCD_i, PC_Plus4D_i,
        output Rs1D_i, Rs2D_i, RdD_i, RegWriteD_i, ResultSrcD_i,
        output MemWriteD_i, JumpD_i, BranchD_i, ALUSrcD_i, ALUControlD_i,
        output stall_i, flush_i,
        input  valid_e_o, RD1E_o, RD2E_o, ImmExtE_o, PCE_o, PC_Plus4E_o,
        input  Rs1E_o, Rs2E_o, RdE_o, RegWriteE_o, ResultSrcE_o,
        input  MemWriteE_o, JumpE_o, BranchE_o, ALUSrcE_o, ALUControlE_o,
        input  lu_stall_o, bubble_cnt_o
    );

    modport slave (
        input  valid_d_i, RD1D_i, RD2D_i, ImmExtD_i, PCD_i, PC_Plus4D_i,
        input  Rs1D_i, Rs2D_i, RdD_i, RegWriteD_i, ResultSrcD_i,
        input  MemWriteD_i, JumpD_i, BranchD_i, ALUSrcD_i, ALUControlD_i,
        input  stall_i, flush_i,
        output valid_e_o, RD1E_o, RD2E_o, ImmExtE_o, PCE_o, PC_Plus4E_o,
        output Rs1E_o, Rs2E_o, RdE_o, RegWriteE_o, ResultSrcE_o,
        output MemWriteE_o, JumpE_o, BranchE_o, ALUSrcE_o, ALUControlE_o,
        output lu_stall_o, bubble_cnt_o
    );
endinterface

// File: rtl/decode_execute_reg.sv
// Decode->execute pipeline register with load-use hazard detection,
// bubble insertion on hazard/flush and a saturating bubble counter.
module decode_execute_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input logic                clk,
    input logic                rst_n,
    decode_execute_reg_if.slave bus
);
    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] rd1;
        logic [DATA_WIDTH-1:0] rd2;
        logic [DATA_WIDTH-1:0] imm;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pc4;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_write;
        logic                  jump;
        logic                  branch;
        logic                  alu_src;
        logic [3:0]            alu_ctrl;
    } e_t;

    e_t                   r_e;
    e_t                   w_load;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_lu_stall;

    // A load in E whose target is read by the instruction in D.
    assign w_lu_stall = r_e.valid & r_e.reg_write
                      & (r_e.result_src == 2'b01)
                      & (r_e.rd != 5'd0) & bus.valid_d_i
                      & ((r_e.rd == bus.Rs1D_i) | (r_e.rd == bus.Rs2D_i));

    always_comb begin
        w_load       = '0;
        w_load.valid = bus.valid_d_i;
        w_load.rd1   = bus.RD1D_i;
        w_load.rd2   = bus.RD2D_i;
        w_load.imm   = bus.ImmExtD_i;
        w_load.pc    = bus.PCD_i;
        w_load.pc4   = bus.PC_Plus4D_i;
        w_load.rs1   = bus.Rs1D_i;
        w_load.rs2   = bus.Rs2D_i;
        w_load.rd    = bus.RdD_i;
        if (bus.valid_d_i) begin
            w_load.reg_write  = bus.RegWriteD_i;
            w_load.result_src = bus.ResultSrcD_i;
            w_load.mem_write  = bus.MemWriteD_i;
            w_load.jump       = bus.JumpD_i;
            w_load.branch     = bus.BranchD_i;
            w_load.alu_src    = bus.ALUSrcD_i;
            w_load.alu_ctrl   = bus.ALUControlD_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e   <= '0;
            r_cnt <= '0;
        end else if (bus.flush_i) begin
            r_e <= '0;
        end else if (bus.stall_i) begin
            r_e <= r_e;
        end else if (w_lu_stall) begin
            r_e <= '0;
            if (r_cnt != {CNT_WIDTH{1'b1}})
                r_cnt <= r_cnt + 1'b1;
        end else begin
            r_e <= w_load;
        end
    end

    assign bus.valid_e_o     = r_e.valid;
    assign bus.RD1E_o        = r_e.rd1;
    assign bus.RD2E_o        = r_e.rd2;
    assign bus.ImmExtE_o     = r_e.imm;
    assign bus.PCE_o         = r_e.pc;
    assign bus.PC_Plus4E_o   = r_e.pc4;
    assign bus.Rs1E_o        = r_e.rs1;
    assign bus.Rs2E_o        = r_e.rs2;
    assign bus.RdE_o         = r_e.rd;
    assign bus.RegWriteE_o   = r_e.reg_write;
    assign bus.ResultSrcE_o  = r_e.result_src;
    assign bus.MemWriteE_o   = r_e.mem_write;
    assign bus.JumpE_o       = r_e.jump;
    assign bus.BranchE_o     = r_e.branch;
    assign bus.ALUSrcE_o     = r_e.alu_src;
    assign bus.ALUControlE_o = r_e.alu_ctrl;
    assign bus.lu_stall_o    = w_lu_stall;
    assign bus.bubble_cnt_o  = r_cnt;
endmodule

// File: doc/decode_execute_reg.md
Name: decode_execute_reg

Overview:
- Pipeline register between the decode stage and the execute stage of the 5-stage RV32I core.
- Captures the decode stage's datapath outputs, its control word and the source/destination register addresses.
- Detects load-use hazards against the instruction currently held in execute, and inserts bubbles for them and on branch/jump flush.
- Keeps a saturating count of the load-use bubbles it inserts, for performance monitoring.

Parameters:
- DATA_WIDTH, 32, width of the datapath fields (RD1, RD2, ImmExt, PC, PC+4).
- CNT_WIDTH, 16, width of the bubble counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_d_i  in  1  decode stage holds a real instruction.
- RD1D_i  in  DATA_WIDTH  register file read data 1.
- RD2D_i  in  DATA_WIDTH  register file read data 2.
- ImmExtD_i  in  DATA_WIDTH  sign-extended immediate.
- PCD_i  in  DATA_WIDTH  PC of the decode instruction.
- PC_Plus4D_i  in  DATA_WIDTH  PC+4 of the decode instruction.
- Rs1D_i  in  5  source register 1 address (instr[19:15]).
- Rs2D_i  in  5  source register 2 address (instr[24:20]).
- RdD_i  in  5  destination register address (instr[11:7]).
- RegWriteD_i  in  1  control: register write enable.
- ResultSrcD_i  in  2  control: 00 ALU, 01 memory, 10 PC+4.
- MemWriteD_i  in  1  control: memory write.
- JumpD_i  in  1  control: jump.
- BranchD_i  in  1  control: branch.
- ALUSrcD_i  in  1  control: ALU operand B select.
- ALUControlD_i  in  4  control: ALU operation.
- stall_i  in  1  downstream freeze; hold all E-stage contents.
- flush_i  in  1  branch/jump taken in execute; squash the incoming instruction.
- All inputs above have matching outputs with the D suffix replaced by E (RD1E_o ... ALUControlE_o), plus:
- valid_e_o  out  1  execute stage holds a real instruction.
- lu_stall_o  out  1  load-use hazard; fetch and decode must hold.
- bubble_cnt_o  out  CNT_WIDTH  number of load-use bubbles inserted.

Behaviour:
- Reset: rst_n low clears every output register to 0 immediately (asynchronous), including valid_e_o and bubble_cnt_o. Release is synchronous to the next rising edge.
- Hazard detect is combinational from E registers and D inputs. lu_stall_o = valid_e_o & RegWriteE_o & (ResultSrcE_o==2'b01) & (RdE_o!=0) & valid_d_i & ((RdE_o==Rs1D_i) | (RdE_o==Rs2D_i)).
- Register update per rising edge, highest priority first:
  1. flush_i=1: insert bubble. All outputs are written to 0 and valid_e_o becomes 0.
  2. stall_i=1: hold all E outputs unchanged. No bubble is counted, even if lu_stall_o=1.
  3. lu_stall_o=1: insert a bubble as in step 1, and bubble_cnt_o increments by 1.
  4. Otherwise, load all D inputs.
     - valid_e_o takes valid_d_i.
     - If valid_d_i=0, all control fields are loaded as 0 and data fields are loaded normally.
- Bubble encoding: RegWriteE_o=0 and MemWriteE_o=0 guarantee a bubble has no architectural effect.
- Latency: a loaded instruction appears on the E outputs one cycle after it is presented on the D inputs.
- Counter: bubble_cnt_o saturates at all-ones and does not wrap. Flush bubbles are not counted.
- Back-to-back load-use: after one bubble, valid_e_o=0, so lu_stall_o drops and the dependent instruction loads on the following cycle. The stall therefore lasts exactly one cycle.
- x0 destination never creates a hazard.
- Reset asserted mid-stall clears all state. lu_stall_o is 0 while in reset.

Test Plan:
1. Reset sequence:
   - Drive the D inputs non-zero and hold rst_n=0 for 3 cycles. All E outputs, valid_e_o and bubble_cnt_o read 0.
   - Release reset. The next edge loads the D values, e.g. PCD_i=0x00000010 gives PCE_o=0x00000010.
2. Normal pass-through:
   - Present RD1D_i=0xDEADBEEF, RdD_i=5, RegWriteD_i=1 with valid_d_i=1.
   - One edge later: RD1E_o=0xDEADBEEF, RdE_o=5, valid_e_o=1.
3. Load-use hazard:
   - E holds lw x7 (RegWriteE=1, ResultSrcE=01, RdE=7). D presents Rs2D_i=7.
   - lu_stall_o=1 in the same cycle.
   - Next edge: bubble, with valid_e_o=0, RegWriteE_o=0, bubble_cnt_o=1.
   - lu_stall_o=0 after that edge, and the held add loads one edge later.
4. No-hazard cases, each giving lu_stall_o=0 and bubble_cnt_o unchanged:
   - lw x0 with Rs1D_i=0.
   - lw x7 with ResultSrcE=00 and Rs1D_i=7.
5. Priority of flush over stall and hazard:
   - flush_i=1 together with stall_i=1 and an active hazard. Next edge: all outputs 0, bubble_cnt_o unchanged.
   - stall_i=1 alone with a hazard: E outputs held, bubble_cnt_o unchanged.
6. Counter saturation:
   - Preload bubble_cnt_o to 0xFFFE via repeated hazards (or a bench-forced short CNT_WIDTH=2 build starting at 2'b10).
   - Two further hazards leave the counter at all-ones.
